mips_fetch_stage: RTL and testbench

MIPS_FETCH_STAGE -- requirements
Module: mips_fetch_stage

---
 rtl/mips_pkg.sv | 26 ++
 rtl/mips_fetch_imem.sv | 23 ++
 rtl/mips_fetch_stage.sv | 152 +++++++++++++++
 tb/tb_mips_fetch_stage.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared constants and types for the MIPS instruction-fetch stage.
//   WORD_W  : datapath / instruction word width
//   NOP     : encoding used to flush the IF/ID latch
//   PC_INC  : sequential PC increment
//   fetch_act_e : the action the fetch stage takes on a given cycle
//   align_pc    : forces a target address onto a word boundary
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam int          WORD_W = 32;
    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam logic [31:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        ACT_ADVANCE,
        ACT_STALL,
        ACT_REDIRECT
    } fetch_act_e;

    function automatic logic [WORD_W-1:0] align_pc(input logic [WORD_W-1:0] addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/mips_fetch_imem.sv
// ---------------------------------------------------------------------------
// fetch_imem
// Instruction memory with a purely combinational read port. The contents
// are not touched by any reset; they are loaded from outside (for example
// by a memory-load system task through the hierarchical path <top>.im0.mem).
// Ports:
//   addr_i  : word index into the memory
//   rdata_o : instruction word stored at addr_i
// ---------------------------------------------------------------------------
module fetch_imem
    import mips_pkg::*;
#(
    parameter int IMEM_DEPTH = 128
) (
    input  logic [$clog2(IMEM_DEPTH)-1:0] addr_i,
    output logic [WORD_W-1:0]             rdata_o
);

    logic [WORD_W-1:0] mem [0:IMEM_DEPTH-1];

    assign rdata_o = mem[addr_i];

endmodule

// File: rtl/mips_fetch_stage.sv
// ---------------------------------------------------------------------------
// mips_fetch_stage
// Instruction-fetch stage: PC register, instruction memory lookup and the
// IF/ID pipeline latch. Per cycle priority is reset > redirect > stall >
// sequential advance.
// Parameters:
//   IMEM_DEPTH : instruction memory depth in words (power of two)
//   RESET_PC   : PC loaded by reset
// Ports:
//   clk, reset        : clock and synchronous active-low reset
//   stall             : hold PC and IF/ID
//   redirect          : load redirect_pc (word aligned) and flush IF/ID
//   redirect_pc       : redirect target
//   pc                : current fetch PC
//   instrout          : instruction at pc (combinational)
//   ifid_instr/_pc4   : IF/ID latched instruction and its pc+4
//   ifid_valid        : IF/ID holds a real fetched instruction
//   fetch_count, stall_count : performance counters, only present when
//                      the MIPS_FETCH_PERF_EN macro is defined
// ---------------------------------------------------------------------------
module mips_fetch_stage
    import mips_pkg::*;
#(
    parameter int          IMEM_DEPTH = 128,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] instrout,
    output logic [WORD_W-1:0] ifid_instr,
    output logic [WORD_W-1:0] ifid_pc4,
`ifdef MIPS_FETCH_PERF_EN
    output logic [WORD_W-1:0] fetch_count,
    output logic [WORD_W-1:0] stall_count,
`endif
    output logic              ifid_valid
);

    localparam int AW = $clog2(IMEM_DEPTH);

    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] ifid_instr_q, ifid_instr_d;
    logic [WORD_W-1:0] ifid_pc4_q, ifid_pc4_d;
    logic              ifid_valid_q, ifid_valid_d;
    logic [WORD_W-1:0] pc_plus4;
    fetch_act_e        act;

    // The low two bits of a redirect target are dropped by alignment.
    logic unused_redirect_lo;
    assign unused_redirect_lo = ^redirect_pc[1:0];

    // Word index takes only the bits that address the memory, so higher PC
    // bits alias modulo IMEM_DEPTH*4.
    fetch_imem #(
        .IMEM_DEPTH (IMEM_DEPTH)
    ) im0 (
        .addr_i  (pc_q[AW+1:2]),
        .rdata_o (instrout)
    );

    assign pc_plus4 = pc_q + PC_INC;

    // Select this cycle's action; redirect overrides a simultaneous stall.
    always_comb begin
        act = ACT_ADVANCE;
        if (redirect) begin
            act = ACT_REDIRECT;
        end else if (stall) begin
            act = ACT_STALL;
        end
    end

    // Next-state values for the PC and IF/ID latch.
    always_comb begin
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        case (act)
            ACT_REDIRECT: begin
                pc_d         = align_pc(redirect_pc);
                ifid_instr_d = NOP;
                ifid_pc4_d   = '0;
                ifid_valid_d = 1'b0;
            end
            ACT_ADVANCE: begin
                pc_d         = pc_plus4;
                ifid_instr_d = instrout;
                ifid_pc4_d   = pc_plus4;
                ifid_valid_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State registers; reset wins over every other request.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q         <= RESET_PC;
            ifid_instr_q <= NOP;
            ifid_pc4_q   <= '0;
            ifid_valid_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign pc         = pc_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_pc4   = ifid_pc4_q;
    assign ifid_valid = ifid_valid_q;

`ifdef MIPS_FETCH_PERF_EN
    logic [WORD_W-1:0] fetch_count_q, fetch_count_d;
    logic [WORD_W-1:0] stall_count_q, stall_count_d;

    // Counters advance on real fetches and on stall-only cycles; a redirect
    // counts as neither.
    always_comb begin
        fetch_count_d = fetch_count_q;
        stall_count_d = stall_count_q;
        if (act == ACT_ADVANCE) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
        if (act == ACT_STALL) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_mips_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_mips_fetch_stage
// Directed scenarios followed by a randomized run, all compared against a
// behavioural model of the fetch stage kept in this bench.
// ---------------------------------------------------------------------------
module tb_mips_fetch_stage;

    localparam int          DEPTH = 32;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] pc, instrout, ifid_instr, ifid_pc4;
    logic        ifid_valid;
`ifdef MIPS_FETCH_PERF_EN
    logic [31:0] fetch_count, stall_count;
`endif

    mips_fetch_stage #(
        .IMEM_DEPTH (DEPTH),
        .RESET_PC   (RPC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc          (pc),
        .instrout    (instrout),
        .ifid_instr  (ifid_instr),
        .ifid_pc4    (ifid_pc4),
`ifdef MIPS_FETCH_PERF_EN
        .fetch_count (fetch_count),
        .stall_count (stall_count),
`endif
        .ifid_valid  (ifid_valid)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] memModel [DEPTH];
    logic [31:0] mPc, mInstr, mPc4, mFetch, mStall;
    logic        mValid;

    int passCount = 0;
    int checkCount = 0;

    function automatic logic [31:0] memAt(input logic [31:0] addr);
        return memModel[(addr / 4) % DEPTH];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) begin
            passCount++;
        end else begin
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Model update with the inputs present at the edge, then output checks.
    task automatic checkAll();
        checkOutput("pc", pc, mPc);
        checkOutput("instrout", instrout, memAt(mPc));
        checkOutput("ifid_instr", ifid_instr, mInstr);
        checkOutput("ifid_pc4", ifid_pc4, mPc4);
        checkOutput("ifid_valid", {31'b0, ifid_valid}, {31'b0, mValid});
`ifdef MIPS_FETCH_PERF_EN
        checkOutput("fetch_count", fetch_count, mFetch);
        checkOutput("stall_count", stall_count, mStall);
`endif
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
        reset       = r;
        stall       = s;
        redirect    = rd;
        redirect_pc = rpc;
        @(posedge clk);
        if (!r) begin
            mPc = RPC; mInstr = 0; mPc4 = 0; mValid = 0; mFetch = 0; mStall = 0;
        end else if (rd) begin
            mPc = rpc & 32'hFFFF_FFFC; mInstr = 0; mPc4 = 0; mValid = 0;
        end else if (s) begin
            mStall = mStall + 1;
        end else begin
            mInstr = memAt(mPc); mPc4 = mPc + 4; mValid = 1;
            mPc = mPc + 4; mFetch = mFetch + 1;
        end
        #1;
        checkAll();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            memModel[i] = $urandom;
        end
        memModel[0] = 32'hAAAA_0000;
        memModel[1] = 32'hBBBB_0001;
        memModel[2] = 32'hCCCC_0002;
        memModel[3] = 32'hDDDD_0003;
        memModel[8] = 32'h8888_0008;
        for (int i = 0; i < DEPTH; i++) begin
            dut.im0.mem[i] = memModel[i];
        end

        // Reset for one cycle, then sequential fetch
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("reset_pc", pc, RPC);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("first_ifid_A", ifid_instr, 32'hAAAA_0000);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("pc_8", pc, 32'h8);

        // Two stall cycles at pc=8, then resume
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("stall_hold_B", ifid_instr, 32'hBBBB_0001);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("resume_C", ifid_instr, 32'hCCCC_0002);

        // Redirect wins over stall; target aligned
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0022);
        checkOutput("redir_pc", pc, 32'h20);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("redir_mem8", ifid_instr, 32'h8888_0008);

        // Memory aliasing and 32-bit PC wrap
        applyStimulus(1'b1, 1'b0, 1'b1, DEPTH * 4 - 4);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("alias_instr", instrout, 32'hAAAA_0000);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("wrap_pc", pc, 32'h0);

        // Reset asserted during stall and redirect
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0040);
        checkOutput("reset_over_redir", pc, RPC);

        // Counter scenario: 5 fetches and 3 stalls after reset
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
`ifdef MIPS_FETCH_PERF_EN
        checkOutput("perf_fetch5", fetch_count, 32'd5);
        checkOutput("perf_stall3", stall_count, 32'd3);
`endif

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            logic        r, s, rd;
            logic [31:0] tgt;
            r   = ($urandom_range(0, 39) != 0);
            s   = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 7) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            applyStimulus(r, s, rd, tgt);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
